fifo_pixel_unpacker: RTL and testbench

- Sits directly downstream of the 32-bit word FIFO.
- Pops one 32-bit word at a time with the FIFO's r_ack pop strobe and serialises each word into four 8-bit pixels.
- Presents pixels on a valid/ready stream, tagged with start/end-of-line and start/end-of-frame markers derived from a raster position counter.
- Flags underrun when the pixel sink is ready mid-frame but no word is available.

---
 rtl/fifo_pixel_unpacker_pkg.sv | 14 +
 rtl/fifo_pixel_unpacker_raster_counter.sv | 49 ++++
 rtl/fifo_pixel_unpacker.sv | 129 ++++++++++++
 tb/tb_fifo_pixel_unpacker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pixel_unpacker_pkg.sv
// Shared sizes and FSM state type for the FIFO pixel unpacker.
// Imported by the top and the raster counter.
package fifo_pixel_unpacker_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int PIX_SIZE     = 8;
  localparam int PIX_PER_WORD = DATA_SIZE / PIX_SIZE;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/fifo_pixel_unpacker_raster_counter.sv
// Raster position counter for the pixel stream.
// Steps x/y on each accepted pixel and decodes line/frame markers.
module fifo_pixel_unpacker_raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof
);
  import fifo_pixel_unpacker_pkg::*;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic x_last;
  logic y_last;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  assign sol = (x == '0);
  assign eol = x_last;
  assign sof = sol & (y == '0);
  assign eof = x_last & y_last;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_pixel_unpacker.sv
// Pops 32-bit FIFO words and serialises them into a marked
// pixel stream, flagging underrun when the FIFO runs dry mid-frame.
module fifo_pixel_unpacker #(
  parameter int DATA_SIZE = fifo_pixel_unpacker_pkg::DATA_SIZE,
  parameter int PIX_SIZE  = fifo_pixel_unpacker_pkg::PIX_SIZE,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int FIFO_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 r_ack,
  output logic [PIX_SIZE-1:0]  pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sol,
  output logic                 pix_eol,
  output logic                 pix_sof,
  output logic                 pix_eof,
  output logic                 frame_done,
  output logic                 underrun,
  input  logic                 clr_underrun
);
  import fifo_pixel_unpacker_pkg::*;

  localparam int NPIX = DATA_SIZE / PIX_SIZE;
  localparam int BW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LW   = $clog2(FIFO_LAT + 2);

  localparam logic [BW-1:0] LAST_IDX = BW'(NPIX - 1);

  state_t               state;
  state_t               state_nx;
  logic [DATA_SIZE-1:0] word;
  logic [BW-1:0]        byte_idx;
  logic [LW-1:0]        lat_cnt;
  logic                 can_pop;
  logic                 xfer;
  logic                 load;
  logic                 urun_set;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 sol;
  logic                 eol;
  logic                 sof;
  logic                 eof;

  // Fresh FIFO data is only trusted once the pop latency has elapsed
  assign can_pop = ~fifo_empty & (lat_cnt == '0);
  assign xfer    = (state == SHIFT) & pix_ready;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (can_pop) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      state == SHIFT: begin
        if (xfer && byte_idx == LAST_IDX) begin
          if (can_pop) load = 1'b1;
          else state_nx = IDLE;
        end
      end
    endcase
  end

  assign r_ack     = load & ~nRST;
  assign pix_valid = (state == SHIFT);
  assign pix_data  = pix_valid ?
    word[byte_idx*PIX_SIZE +: PIX_SIZE] : '0;

  assign pix_sol = pix_valid & sol;
  assign pix_eol = pix_valid & eol;
  assign pix_sof = pix_valid & sof;
  assign pix_eof = pix_valid & eof;

  assign urun_set = (state == IDLE) & pix_ready & fifo_empty &
                    ((x != '0) | (y != '0));

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      word       <= '0;
      byte_idx   <= '0;
      lat_cnt    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        word     <= fifo_data;
        byte_idx <= '0;
      end else if (xfer) begin
        byte_idx <= byte_idx + 1'b1;
      end
      if (load) lat_cnt <= LW'(FIFO_LAT);
      else if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      frame_done <= xfer & eof;
      if (urun_set) underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

  fifo_pixel_unpacker_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_raster (
    .clk     (clk),
    .nRST    (nRST),
    .advance (xfer),
    .x       (x),
    .y       (y),
    .sol     (sol),
    .eol     (eol),
    .sof     (sof),
    .eof     (eof)
  );

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Bench for fifo_pixel_unpacker: FIFO model plus pixel scoreboard
// on a 6x2 raster.
module tb_fifo_pixel_unpacker;

  localparam int W = 6;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        r_ack;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_sol, pix_eol, pix_sof, pix_eof;
  logic        frame_done;
  logic        underrun;
  logic        clr_underrun = 1'b0;

  always #5 clk = ~clk;

  fifo_pixel_unpacker #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .FIFO_LAT (1)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .r_ack        (r_ack),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_sol      (pix_sol),
    .pix_eol      (pix_eol),
    .pix_sof      (pix_sof),
    .pix_eof      (pix_eof),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       eol;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  p3;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  logic [31:0] pend[$];
  int          checks = 0;
  int          errors = 0;
  int          ex = 0;
  int          ey = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          xfer_cnt = 0;
  int          eof_at = 0;
  int          fd_cnt = 0;
  int          xfer_cyc[$];
  logic [7:0]  ack_bytes[$];
  logic        fd_exp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d = '0;
  logic [3:0]  prev_m = '0;
  logic        rst_q = 1'b0;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // FIFO model: head visible one cycle after each pop
  always @(posedge clk) begin
    if (nRST && !rst_q) fq.delete();
    else if (!nRST && r_ack && fq.size() > 0) void'(fq.pop_front());
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    rst_q <= nRST;
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 32'h0;
  end

  always @(negedge clk) begin
    cyc++;
    if (nRST) begin
      prev_stall = 1'b0;
      fd_exp = 1'b0;
    end else begin
      if (r_ack) begin
        ack_cnt++;
        chk("r_ack_while_empty", fifo_empty, 0);
      end
      if (prev_stall) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, prev_d);
        chk("hold_markers", {pix_sol, pix_eol, pix_sof, pix_eof}, prev_m);
      end
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      if (pix_valid && pix_ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        if (r_ack) ack_bytes.push_back(pix_data);
        if (pix_eof) eof_at = xfer_cnt;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0h want none", pix_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", pix_data, mon_e.d);
          chk("markers", {pix_sol, pix_eol, pix_sof, pix_eof},
              {mon_e.sol, mon_e.eol, mon_e.sof, mon_e.eof});
          fd_exp = mon_e.eof;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_d = pix_data;
      prev_m = {pix_sol, pix_eol, pix_sof, pix_eof};
    end
  end

  task automatic add_pix(input logic [7:0] d);
    exp_t e;
    e.d   = d;
    e.sol = (ex == 0);
    e.eol = (ex == W - 1);
    e.sof = (ex == 0) && (ey == 0);
    e.eof = (ex == W - 1) && (ey == H - 1);
    exp_q.push_back(e);
    if (ex == W - 1) begin
      ex = 0;
      ey = (ey == H - 1) ? 0 : ey + 1;
    end else begin
      ex++;
    end
  endtask

  task automatic push_vec(input vec_t v);
    pend.push_back(v.word);
    add_pix(v.p0);
    add_pix(v.p1);
    add_pix(v.p2);
    add_pix(v.p3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_on();
    nRST = 1'b1;
    pix_ready = 1'b0;
    clr_underrun = 1'b0;
    pend.delete();
    exp_q.delete();
    ex = 0;
    ey = 0;
  endtask

  task automatic rst_off();
    step();
    step();
    nRST = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    step();
    chk(name, exp_q.size(), 0);
  endtask

  vec_t tv1[2];
  vec_t tv3[4];
  int   pat[8];
  int   b_ack, b_xfer, b_cyc, b_ab, b_fd;

  initial begin
    tv1[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
    tv1[1] = '{32'h88776655, 8'h55, 8'h66, 8'h77, 8'h88};
    tv3[0] = '{32'h04030201, 8'h01, 8'h02, 8'h03, 8'h04};
    tv3[1] = '{32'h08070605, 8'h05, 8'h06, 8'h07, 8'h08};
    tv3[2] = '{32'h0c0b0a09, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    tv3[3] = '{32'h100f0e0d, 8'h0d, 8'h0e, 8'h0f, 8'h10};
    pat = '{1, 0, 0, 1, 0, 1, 1, 1};

    // reset values
    rst_on();
    step();
    chk("rst_r_ack", r_ack, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_markers", {pix_sol, pix_eol, pix_sof, pix_eof}, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);

    // two preloaded words streamed without a bubble
    for (int i = 0; i < 2; i++) push_vec(tv1[i]);
    pix_ready = 1'b1;
    b_ack = ack_cnt; b_cyc = xfer_cyc.size(); b_ab = ack_bytes.size();
    rst_off();
    wait_drain("t1_drain", 40);
    step();
    chk("t1_acks", ack_cnt - b_ack, 2);
    chk("t1_ack_on_xfer", ack_bytes.size() - b_ab, 1);
    if (ack_bytes.size() > b_ab) chk("t1_ack_byte", ack_bytes[b_ab], 8'h44);
    if (xfer_cyc.size() >= b_cyc + 8)
      chk("t1_no_bubble", xfer_cyc[b_cyc+7] - xfer_cyc[b_cyc], 7);
    else chk("t1_xfers", xfer_cyc.size() - b_cyc, 8);

    // ready toggling mid-word
    rst_on();
    rst_off();
    push_vec('{32'hddccbbaa, 8'haa, 8'hbb, 8'hcc, 8'hdd});
    b_ack = ack_cnt; b_xfer = xfer_cnt;
    for (int n = 0; n < 20 && !pix_valid; n++) step();
    chk("t2_valid", pix_valid, 1);
    for (int i = 0; i < 8; i++) begin
      pix_ready = pat[i][0];
      step();
    end
    pix_ready = 1'b1;
    wait_drain("t2_drain", 20);
    chk("t2_acks", ack_cnt - b_ack, 1);
    chk("t2_xfers", xfer_cnt - b_xfer, 4);

    // line and frame boundaries on a 6x2 raster
    rst_on();
    pix_ready = 1'b1;
    b_xfer = xfer_cnt; b_fd = fd_cnt;
    for (int i = 0; i < 4; i++) push_vec(tv3[i]);
    rst_off();
    wait_drain("t3_drain", 60);
    step();
    chk("t3_eof_index", eof_at - b_xfer, 12);
    chk("t3_frame_done_cnt", fd_cnt - b_fd, 1);

    // underrun mid-frame, sticky across refill, then cleared
    rst_on();
    rst_off();
    pix_ready = 1'b1;
    push_vec('{32'ha4a3a2a1, 8'ha1, 8'ha2, 8'ha3, 8'ha4});
    wait_drain("t4_drain1", 20);
    repeat (3) step();
    chk("t4_idle", pix_valid, 0);
    chk("t4_underrun_set", underrun, 1);
    push_vec('{32'hb4b3b2b1, 8'hb1, 8'hb2, 8'hb3, 8'hb4});
    wait_drain("t4_drain2", 20);
    repeat (3) step();
    chk("t4_underrun_sticky", underrun, 1);
    pix_ready = 1'b0;
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("t4_underrun_clr", underrun, 0);
    step();
    chk("t4_underrun_stays_clr", underrun, 0);

    // empty FIFO from reset at the frame origin
    rst_on();
    pix_ready = 1'b1;
    rst_off();
    b_ack = ack_cnt;
    repeat (10) step();
    chk("t5_acks", ack_cnt - b_ack, 0);
    chk("t5_valid", pix_valid, 0);
    chk("t5_underrun", underrun, 0);

    // reset after the second byte of a word
    rst_on();
    pix_ready = 1'b1;
    push_vec('{32'h14131211, 8'h11, 8'h12, 8'h13, 8'h14});
    push_vec('{32'h18171615, 8'h15, 8'h16, 8'h17, 8'h18});
    rst_off();
    b_xfer = xfer_cnt;
    for (int n = 0; n < 20 && xfer_cnt - b_xfer < 2; n++) step();
    chk("t6_two_xfers", xfer_cnt - b_xfer, 2);
    rst_on();
    pix_ready = 1'b1;
    #1;
    chk("t6_rst_valid", pix_valid, 0);
    chk("t6_rst_data", pix_data, 0);
    chk("t6_rst_r_ack", r_ack, 0);
    chk("t6_rst_markers", {pix_sol, pix_eol, pix_sof, pix_eof}, 0);
    step();
    nRST = 1'b0;
    push_vec('{32'h2c2b2a29, 8'h29, 8'h2a, 8'h2b, 8'h2c});
    wait_drain("t6_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
